// File: rtl/fetch_pkg.sv
// Shared types for the fetch buffer: queue entry layout and occupancy width helper.
`include "cpu_config.svh"

package fetch_pkg;

  localparam int ADDR_W = `AddrWidth;
  localparam int INST_W = `InstWidth;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  // Occupancy needs one extra bit so that "full" (== depth) is representable.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cpu_config.svh
// Core-wide width configuration shared by the fetch slice.
`ifndef CPU_CONFIG_SVH
`define CPU_CONFIG_SVH

`define AddrWidth 32
`define InstWidth 32

`endif

// File: rtl/fetch_queue.sv
// DEPTH-entry circular queue of {inst, pc} entries between fetch and decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = occ_width(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         enq_i,
  input  logic         deq_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_ || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({enq_i, deq_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an empty queue masks its head to zero instead.
  always_ff @(posedge clk) begin
    if (enq_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_buf_ctrl.sv
// Fetch PC owner plus decoupling queue toward decode.
// Optional same-cycle empty-queue bypass enabled by defining FETCH_BUF_BYPASS_EN.
module fetch_buf_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR = ADDR_W,
  parameter int INST = INST_W,
  parameter int DEPTH = 4,
  parameter logic [ADDR-1:0] RESET_PC = '0,
  localparam int CW = occ_width(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            ic_stall_,
  input  logic [INST-1:0] ic_inst,
  input  logic [ADDR-1:0] next_fetch_pc,
  output logic [ADDR-1:0] fetch_pc,
  output logic            fetch_stall_,
  output logic            inst_e_,
  output logic [INST-1:0] inst,
  output logic [ADDR-1:0] inst_pc,
  input  logic            dec_stall,
  input  logic            wb_flush_,
  input  logic [ADDR-1:0] wb_pc,
  output logic [CW-1:0]   fq_count
);

  logic [ADDR-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count;
  fetch_entry_t    wr_entry, q_head, head;
  logic            run, empty, enq, deq, q_enq;

  assign run   = reset_ & wb_flush_;
  assign empty = (count == '0);
  // Full check uses pre-dequeue occupancy: a same-cycle pop never frees the slot.
  assign enq   = run & ic_stall_ & (count < CW'(DEPTH));
  assign deq   = run & ~empty & ~dec_stall;

  assign wr_entry = '{inst: ic_inst, pc: fetch_pc_q};

`ifdef FETCH_BUF_BYPASS_EN
  logic byp;
  assign byp     = empty & enq;
  assign q_enq   = enq & ~(byp & ~dec_stall);
  assign head    = byp ? wr_entry : q_head;
  assign inst_e_ = empty & ~byp;
`else
  assign q_enq   = enq;
  assign head    = q_head;
  assign inst_e_ = empty;
`endif

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .reset_  (reset_),
    .enq_i   (q_enq),
    .deq_i   (deq),
    .flush_i (~wb_flush_),
    .data_i  (wr_entry),
    .head_o  (q_head),
    .count_o (count)
  );

  // NOTE: always_comb assigns a default first so no path can leave fetch_pc_d unassigned (latch).
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (!wb_flush_) fetch_pc_d = wb_pc;
    else if (enq)   fetch_pc_d = next_fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (!reset_) fetch_pc_q <= RESET_PC;
    else         fetch_pc_q <= fetch_pc_d;
  end

  assign fetch_pc     = fetch_pc_q;
  assign fetch_stall_ = enq;
  assign inst         = head.inst;
  assign inst_pc      = head.pc;
  assign fq_count     = count;

endmodule
